// File: rtl/core_pkg.sv
// Shared types and sizing for the reorder buffer and the rename-side logic
// that consumes its lookup and commit outputs.
package core_pkg;

    localparam int WIDTH     = 31;
    localparam int ROB       = 2;
    localparam int REG       = 4;
    localparam int ROB_DEPTH = 1 << (ROB + 1);

    typedef logic [ROB:0]   rob_tag_t;
    typedef logic [REG:0]   reg_idx_t;
    typedef logic [WIDTH:0] data_t;
    typedef logic [ROB+1:0] rob_count_t;

    typedef struct packed {
        logic  ready;
        data_t value;
    } rob_lookup_t;

    typedef struct packed {
        logic     busy;
        logic     ready;
        reg_idx_t dest;
        data_t    value;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Bundle of the allocate, CDB, operand-lookup and commit signals exchanged
// between the rename/retire side (master) and the reorder buffer (slave).
interface reorder_buffer_if;
    import core_pkg::*;

    logic        alloc_valid;
    reg_idx_t    alloc_dest;
    logic        alloc_ready;
    rob_tag_t    alloc_rob;

    logic        cdb_valid;
    rob_tag_t    cdb_rob;
    data_t       cdb_value;

    rob_tag_t    rob1;
    rob_tag_t    rob2;
    rob_lookup_t ROBValue1;
    rob_lookup_t ROBValue2;

    logic        commit_ready;
    logic        commit_valid;
    rob_tag_t    freedRob;
    reg_idx_t    commitDest;
    data_t       ROBCommit;

    modport master (
        output alloc_valid, alloc_dest, cdb_valid, cdb_rob, cdb_value,
               rob1, rob2, commit_ready,
        input  alloc_ready, alloc_rob, ROBValue1, ROBValue2,
               commit_valid, freedRob, commitDest, ROBCommit
    );

    modport slave (
        input  alloc_valid, alloc_dest, cdb_valid, cdb_rob, cdb_value,
               rob1, rob2, commit_ready,
        output alloc_ready, alloc_rob, ROBValue1, ROBValue2,
               commit_valid, freedRob, commitDest, ROBCommit
    );

endinterface

// File: rtl/rob_lookup_port.sv
// Combinational source-operand lookup into the ROB, with a same-cycle
// forward from the CDB when the entry has not captured its result yet.
module rob_lookup_port
    import core_pkg::*;
(
    input  rob_tag_t               tag,
    input  logic [ROB_DEPTH-1:0]   busy,
    input  logic [ROB_DEPTH-1:0]   ready,
    input  data_t                  value [ROB_DEPTH],
    input  logic                   cdb_valid,
    input  rob_tag_t               cdb_rob,
    input  data_t                  cdb_value,
    output rob_lookup_t            result
);

    always_comb begin
        result = '0;
        if (busy[tag] && ready[tag]) begin
            result.ready = 1'b1;
            result.value = value[tag];
        end else if (cdb_valid && (cdb_rob == tag) && busy[tag]) begin
            result.ready = 1'b1;
            result.value = cdb_value;
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates in rename order, captures CDB results,
// serves operand lookups and retires in order from the head.
module reorder_buffer
    import core_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    reorder_buffer_if.slave   bus
);

    rob_entry_t           entries [ROB_DEPTH];
    rob_tag_t             head;
    rob_tag_t             tail;
    rob_count_t           count;

    logic                 full;
    logic                 allocFire;
    logic                 retire;
    logic                 cdbHit;
    logic [ROB_DEPTH-1:0] busyVec;
    logic [ROB_DEPTH-1:0] readyVec;
    data_t                valueVec [ROB_DEPTH];

    always_comb begin
        for (int i = 0; i < ROB_DEPTH; i++) begin
            busyVec[i]  = entries[i].busy;
            readyVec[i] = entries[i].ready;
            valueVec[i] = entries[i].value;
        end
    end

    // No full-bypass: a retire in the same cycle does not open a slot.
    assign full          = (count == rob_count_t'(ROB_DEPTH));
    assign bus.alloc_ready = !full;
    assign bus.alloc_rob   = tail;
    assign allocFire     = bus.alloc_valid && !full;
    assign cdbHit        = bus.cdb_valid && entries[bus.cdb_rob].busy;

    assign bus.commit_valid = entries[head].busy && entries[head].ready;
    assign bus.freedRob     = head;
    assign bus.commitDest   = bus.commit_valid ? entries[head].dest  : '0;
    assign bus.ROBCommit    = bus.commit_valid ? entries[head].value : '0;
    assign retire           = bus.commit_valid && bus.commit_ready;

    // Flush outranks everything; otherwise CDB capture, then retire, then
    // allocate, so a (never legal) allocate/CDB collision resolves to allocate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) begin
                entries[i].busy  <= 1'b0;
                entries[i].ready <= 1'b0;
            end
        end else begin
            if (cdbHit) begin
                entries[bus.cdb_rob].value <= bus.cdb_value;
                entries[bus.cdb_rob].ready <= 1'b1;
            end
            if (retire) begin
                entries[head].busy  <= 1'b0;
                entries[head].ready <= 1'b0;
                head                <= head + rob_tag_t'(1);
            end
            if (allocFire) begin
                entries[tail].busy  <= 1'b1;
                entries[tail].ready <= 1'b0;
                entries[tail].dest  <= bus.alloc_dest;
                tail                <= tail + rob_tag_t'(1);
            end
            count <= count + rob_count_t'(allocFire) - rob_count_t'(retire);
        end
    end

    rob_lookup_port lookup1 (
        .tag       (bus.rob1),
        .busy      (busyVec),
        .ready     (readyVec),
        .value     (valueVec),
        .cdb_valid (bus.cdb_valid),
        .cdb_rob   (bus.cdb_rob),
        .cdb_value (bus.cdb_value),
        .result    (bus.ROBValue1)
    );

    rob_lookup_port lookup2 (
        .tag       (bus.rob2),
        .busy      (busyVec),
        .ready     (readyVec),
        .value     (valueVec),
        .cdb_valid (bus.cdb_valid),
        .cdb_rob   (bus.cdb_rob),
        .cdb_value (bus.cdb_value),
        .result    (bus.ROBValue2)
    );

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular reorder buffer that produces every ROB-side signal the rename-stage operand logic consumes.
- Produced signals: per-source lookups with a valid bit (ROBValue1/ROBValue2), the committing tag (freedRob) and the committing value (ROBCommit).
- Allocates one entry per renamed instruction and captures results from the common data bus (CDB).
- Retires in order to the register file and register-status file.

Parameters:
- WIDTH, 31, MSB index of data value (32-bit data).
- ROB, 2, MSB index of ROB tag; depth = 2^(ROB+1) = 8 entries.
- REG, 4, MSB index of architectural register number (32 registers).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  discard all entries (mispredict recovery).
- alloc_valid  in  1  rename requests an entry this cycle.
- alloc_dest  in  REG+1  destination register of allocating instruction.
- alloc_ready  out  1  entry available (not full).
- alloc_rob  out  ROB+1  tag of the tail entry; valid when alloc_ready.
- cdb_valid  in  1  result broadcast valid.
- cdb_rob  in  ROB+1  tag of broadcasting instruction.
- cdb_value  in  WIDTH+1  broadcast result.
- rob1, rob2  in  ROB+1  lookup tags for source operands 1 and 2.
- ROBValue1, ROBValue2  out  WIDTH+2  MSB = value ready, [WIDTH:0] = value.
- commit_ready  in  1  register file accepts a retirement this cycle.
- commit_valid  out  1  head entry is allocated and has its result.
- freedRob  out  ROB+1  head tag.
- commitDest  out  REG+1  head destination register.
- ROBCommit  out  WIDTH+1  head result value.

Behaviour:
- Per-entry state: busy, ready, dest[REG:0], value[WIDTH:0].
- Pointers head/tail are ROB+1 bits, wrapping modulo depth. count is ROB+2 bits.
- Empty condition: count==0. Full condition: count==2^(ROB+1).
- Reset (async, rst_n=0):
  - head=tail=count=0; all busy/ready cleared.
  - Output reset values: alloc_ready=1, alloc_rob=0, commit_valid=0, freedRob=0, commitDest=0, ROBCommit=0, ROBValue1/2 MSB=0.
- Reset mid-operation discards all entries immediately; there is no drain.
- Allocate:
  - Condition: alloc_valid & alloc_ready.
  - Entry[tail]: busy=1, ready=0, dest=alloc_dest. Then tail++ and count++.
  - alloc_valid while full is ignored with no state change.
- CDB write:
  - Condition: cdb_valid and entry[cdb_rob].busy.
  - Action: value=cdb_value, ready=1.
  - cdb_valid to a non-busy entry is ignored.
- Lookup (combinational), for operand n:
  - If entry[robn].busy & ready: ROBValuen = {1, value}.
  - Else if cdb_valid & cdb_rob==robn & entry busy: ROBValuen = {1, cdb_value} (same-cycle forward).
  - Else ROBValuen = {0, 0}.
- Commit outputs:
  - Combinational from entry[head]; commit_valid = busy & ready.
  - When commit_valid=0, freedRob still equals head, but commitDest/ROBCommit drive 0.
- Retire: on commit_valid & commit_ready, clear entry[head].busy/ready, head++, count--.
- CDB write to the head entry is visible at commit the following cycle only (no CDB-to-commit bypass).
- Simultaneous allocate and retire:
  - Both occur; count is unchanged.
  - Allowed while not full. When full, alloc_ready=0 that cycle even if a retire happens (no full-bypass).
- Simultaneous allocate and CDB write to the same index: impossible in a legal stream; the allocate wins.
- Flush:
  - Synchronous, highest priority: head=tail=count=0, all busy/ready cleared.
  - Same-cycle allocate, CDB and retire are dropped; commit_valid is still driven combinationally that cycle.
- Latencies: allocate to lookup visibility is 1 cycle; CDB to lookup is 0 cycles (forward); CDB to commit_valid is 1 cycle.

Decomposition:
- Shared package core_pkg holds:
  - rob_tag_t [ROB:0], reg_idx_t [REG:0], data_t [WIDTH:0].
  - rob_lookup_t {ready, data_t}.
  - rob_entry_t {busy, ready, dest, value}.
  - ROB_DEPTH constant.
- One natural sub-module, rob_lookup_port (instanced twice), implements the combinational tag lookup plus CDB forward.

Test Plan:
- Reset, then allocate 8 (dest 1..8) -> alloc_rob 0..7 in order; after the 8th, alloc_ready=0; a 9th alloc_valid causes no change.
- CDB tag 3 value 0xDEADBEEF with rob1=3 in the same cycle -> ROBValue1=0x1_DEADBEEF that cycle and held afterwards; rob2=4 (not ready) -> ROBValue2=0.
- Head tag 0 not ready, CDB writes tags 1 and 2 -> commit_valid=0. Then CDB tag 0 value 5 -> next cycle commit_valid=1, freedRob=0, ROBCommit=5. With commit_ready=1, retire 0,1,2 on consecutive cycles.
- Full buffer with head ready, alloc_valid and commit_ready both 1 -> retire only, count 7. Next cycle alloc_ready=1; allocate+retire together keeps count 7 and wraps tail 7->0.
- Flush with 5 entries busy and a same-cycle CDB -> count=0, all lookups MSB=0, commit_valid=0 next cycle, alloc_rob=0.
- rst_n pulsed low asynchronously mid-stream (between clock edges) -> all outputs at reset values immediately; first allocate after release gets tag 0.
